alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 2, meaning number of requester ports; only the value 2 is supported.
REQ-002 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have ports rN_valid (input, 1) and rN_ready (output, 1) for N=0,1, forming the request handshake.
REQ-005 SHALL have ports rN_opcode (input, 5), rN_shamt (input, 5), rN_a (input, 32) and rN_b (input, 32), giving the request payload per port.
REQ-006 SHALL have ports rsp_valid (output, 1), rsp_ready (input, 1) and rsp_id (output, 1, granted port), forming the response handshake.
REQ-007 SHALL have ports rsp_data (output, 32), rsp_ne, rsp_lt, rsp_ovf and rsp_err (outputs, 1 each), giving the result and flags.

Function
REQ-008 SHALL use an FSM with states IDLE, EXEC and RESP; EXEC exists only with ALU_ARB_PIPE_EN.
REQ-009 SHALL, in IDLE, assert rN_ready only for the granted port, and only while that port's rN_valid is high.
REQ-010 SHALL arbitrate round-robin: a lone valid port is granted; with both valid, the port not granted last wins.
REQ-011 SHALL latch the grant's payload at the accept edge (valid && ready) and update last_grant at that same edge.
REQ-012 SHALL pass operands to the shared ALU with opcode sel: 00000 add, 00001 sub, 00010 and, 00011 or, 00100 sll, 00101 sra, 01000 xor.
REQ-013 SHALL treat any other opcode as illegal: rsp_err=1, rsp_data=0, rsp_ne/lt/ovf=0, and the ALU result ignored.
REQ-014 SHALL register rsp_data and all flags, and hold them stable in RESP until rsp_ready.
REQ-015 SHALL assert rsp_valid only in RESP; rsp_valid && rsp_ready returns the FSM to IDLE.
REQ-016 SHALL accept at most one outstanding request; no rN_ready is asserted outside IDLE.
REQ-017 SHALL, when rsp_ready is held high, give a throughput of 1 op per 2 cycles (1 per 3 with the pipe stage).
REQ-018 SHALL keep rsp_ovf meaningful only for add/sub; it is forced to 0 for all other ops.
REQ-019 SHALL NOT let a requester dropping valid before its grant affect state.

Reset
REQ-020 SHALL, on reset, force the FSM to IDLE, last_grant=1 (port 0 preferred first), rsp_valid=0, rsp_data=0, all flags=0, rsp_id=0 and rN_ready=0.
REQ-021 SHALL, on reset mid-transaction (EXEC/RESP), discard the transaction with no response produced.

Configuration
REQ-022 SHALL use macro ALU_ARB_PIPE_EN: when defined, the payload is registered, the ALU is evaluated in EXEC, and rsp_valid is asserted 2 cycles after accept.
REQ-023 SHALL, without ALU_ARB_PIPE_EN, feed the ALU from the muxed live request and capture its result at the accept edge, with rsp_valid asserted 1 cycle after accept.

Structure
REQ-024 SHALL place the FSM state encoding and the legal-opcode constants (ADD, SUB, AND, OR, SLL, SRA, XOR) in shared package alu_pkg.
REQ-025 SHALL implement the round-robin pick as sub-module rr_arb2 (inputs: req[1:0], last; output: gnt[1:0]).
REQ-026 SHALL instantiate exactly one copy of the team's 32-bit ALU (tkm19_alu).

Verification
REQ-027 SHALL verify: r0 add a=7 b=5, rsp_ready=1 -> rsp_data=12, rsp_id=0, ne=1, lt=0, ovf=0, after 1 cycle (2 with PIPE).
REQ-028 SHALL verify: r0 and r1 both valid from reset, each with sub 0x7FFFFFFF - 0xFFFFFFFF -> port 0 served first, then port 1; both results ovf=1.
REQ-029 SHALL verify: r1 opcode 00110 -> rsp_err=1, rsp_data=0, flags 0; the next r1 sll a=1 shamt=31 -> rsp_data=0x80000000.
REQ-030 SHALL verify: rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_data stable, and r0_ready/r1_ready stay 0.
REQ-031 SHALL verify: reset asserted in RESP -> rsp_valid=0 immediately; after release, r0 is granted first when both are valid.
REQ-032 SHALL verify: r0 xor a=0xFFFF0000 b=0x0F0F0F0F -> rsp_data=0xF0F00F0F.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: FSM state encoding, legal opcodes and
// opcode classification helpers.
// Optional feature macro: ALU_ARB_PIPE_EN (adds the EXEC state).
package alu_pkg;

`ifdef ALU_ARB_PIPE_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RESP = 2'd2
  } arb_state_t;
`endif

  localparam logic [4:0] OP_ADD = 5'b00000;
  localparam logic [4:0] OP_SUB = 5'b00001;
  localparam logic [4:0] OP_AND = 5'b00010;
  localparam logic [4:0] OP_OR  = 5'b00011;
  localparam logic [4:0] OP_SLL = 5'b00100;
  localparam logic [4:0] OP_SRA = 5'b00101;
  localparam logic [4:0] OP_XOR = 5'b01000;

  // True for the seven opcodes the ALU implements.
  function automatic logic op_is_legal(input logic [4:0] op);
    logic legal;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLL, OP_SRA, OP_XOR: legal = 1'b1;
      default:                                              legal = 1'b0;
    endcase
    return legal;
  endfunction

  // True for the opcodes whose overflow flag carries meaning.
  function automatic logic op_has_ovf(input logic [4:0] op);
    logic has;
    case (op)
      OP_ADD, OP_SUB: has = 1'b1;
      default:        has = 1'b0;
    endcase
    return has;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a lone request wins; on a tie the port that was
// not granted last wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  // One-hot grant from the request pair and the last-granted port.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/tkm19_alu.sv
// 32-bit combinational ALU: add/sub/and/or/sll/sra/xor plus compare flags.
// ne/lt compare the operands (lt is signed); ovf is signed overflow of add/sub.
module tkm19_alu
  import alu_pkg::*;
(
  input  logic [4:0]  i_op,
  input  logic [4:0]  i_shamt,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_y,
  output logic        o_ne,
  output logic        o_lt,
  output logic        o_ovf
);

  logic [31:0] w_sum;
  logic [31:0] w_diff;

  assign w_sum  = i_a + i_b;
  assign w_diff = i_a - i_b;
  assign o_ne   = (i_a != i_b);
  assign o_lt   = ($signed(i_a) < $signed(i_b));

  // Operation select and overflow detection.
  always_comb begin
    o_y   = 32'd0;
    o_ovf = 1'b0;
    case (i_op)
      OP_ADD: begin
        o_y   = w_sum;
        o_ovf = (i_a[31] == i_b[31]) && (w_sum[31] != i_a[31]);
      end
      OP_SUB: begin
        o_y   = w_diff;
        o_ovf = (i_a[31] != i_b[31]) && (w_diff[31] != i_a[31]);
      end
      OP_AND:  o_y = i_a & i_b;
      OP_OR:   o_y = i_a | i_b;
      OP_SLL:  o_y = i_a << i_shamt;
      OP_SRA:  o_y = $unsigned($signed(i_a) >>> i_shamt);
      OP_XOR:  o_y = i_a ^ i_b;
      default: begin
        o_y   = 32'd0;
        o_ovf = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of one shared ALU with a registered response.
// One transaction in flight at a time. Optional macro ALU_ARB_PIPE_EN registers
// the payload and evaluates the ALU in an extra EXEC cycle.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        r0_valid,
  output logic        r0_ready,
  input  logic [4:0]  r0_opcode,
  input  logic [4:0]  r0_shamt,
  input  logic [31:0] r0_a,
  input  logic [31:0] r0_b,
  input  logic        r1_valid,
  output logic        r1_ready,
  input  logic [4:0]  r1_opcode,
  input  logic [4:0]  r1_shamt,
  input  logic [31:0] r1_a,
  input  logic [31:0] r1_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_data,
  output logic        rsp_ne,
  output logic        rsp_lt,
  output logic        rsp_ovf,
  output logic        rsp_err
);

  arb_state_t r_state;
  arb_state_t w_state_nxt;
  logic       r_last_grant;

  logic [NREQ-1:0] w_req;
  logic [NREQ-1:0] w_gnt;
  logic            w_accept;
  logic            w_sel;
  logic            w_capture;

  logic [4:0]  w_alu_op;
  logic [4:0]  w_alu_shamt;
  logic [31:0] w_alu_a;
  logic [31:0] w_alu_b;
  logic [31:0] w_alu_y;
  logic        w_alu_ne;
  logic        w_alu_lt;
  logic        w_alu_ovf;
  logic        w_legal;

  logic        r_rsp_valid;
  logic        r_rsp_id;
  logic [31:0] r_rsp_data;
  logic        r_rsp_ne;
  logic        r_rsp_lt;
  logic        r_rsp_ovf;
  logic        r_rsp_err;

  assign w_req = {r1_valid, r0_valid};

  rr_arb2 u_rr_arb2 (
    .req  (w_req),
    .last (r_last_grant),
    .gnt  (w_gnt)
  );

  // A grant only exists while its port is valid, so any grant in IDLE is an accept.
  assign w_accept = (r_state == IDLE) && (w_gnt != 2'b00);
  assign w_sel    = w_gnt[1];

`ifdef ALU_ARB_PIPE_EN
  logic [4:0]  r_op;
  logic [4:0]  r_shamt;
  logic [31:0] r_a;
  logic [31:0] r_b;

  // Latch the granted payload at the accept edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_op    <= 5'd0;
      r_shamt <= 5'd0;
      r_a     <= 32'd0;
      r_b     <= 32'd0;
    end else if (w_accept) begin
      r_op    <= w_sel ? r1_opcode : r0_opcode;
      r_shamt <= w_sel ? r1_shamt  : r0_shamt;
      r_a     <= w_sel ? r1_a      : r0_a;
      r_b     <= w_sel ? r1_b      : r0_b;
    end
  end

  assign w_alu_op    = r_op;
  assign w_alu_shamt = r_shamt;
  assign w_alu_a     = r_a;
  assign w_alu_b     = r_b;
  assign w_capture   = (r_state == EXEC);
`else
  assign w_alu_op    = w_sel ? r1_opcode : r0_opcode;
  assign w_alu_shamt = w_sel ? r1_shamt  : r0_shamt;
  assign w_alu_a     = w_sel ? r1_a      : r0_a;
  assign w_alu_b     = w_sel ? r1_b      : r0_b;
  assign w_capture   = w_accept;
`endif

  tkm19_alu u_alu (
    .i_op    (w_alu_op),
    .i_shamt (w_alu_shamt),
    .i_a     (w_alu_a),
    .i_b     (w_alu_b),
    .o_y     (w_alu_y),
    .o_ne    (w_alu_ne),
    .o_lt    (w_alu_lt),
    .o_ovf   (w_alu_ovf)
  );

  assign w_legal = op_is_legal(w_alu_op);

  // FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic and request-side ready outputs.
  always_comb begin
    w_state_nxt = r_state;
    r0_ready    = 1'b0;
    r1_ready    = 1'b0;
    case (r_state)
      IDLE: begin
        r0_ready = w_gnt[0];
        r1_ready = w_gnt[1];
        if (w_accept) begin
`ifdef ALU_ARB_PIPE_EN
          w_state_nxt = EXEC;
`else
          w_state_nxt = RESP;
`endif
        end else begin
          w_state_nxt = IDLE;
        end
      end
`ifdef ALU_ARB_PIPE_EN
      EXEC: w_state_nxt = RESP;
`endif
      RESP: begin
        if (rsp_ready) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = RESP;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Round-robin history and response id follow the accepted port.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_last_grant <= 1'b1;
      r_rsp_id     <= 1'b0;
    end else if (w_accept) begin
      r_last_grant <= w_sel;
      r_rsp_id     <= w_sel;
    end
  end

  // Response valid tracks entry into RESP so it is a clean register output.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rsp_valid <= 1'b0;
    end else begin
      r_rsp_valid <= (w_state_nxt == RESP);
    end
  end

  // Capture result and flags; illegal opcodes report err with everything else zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rsp_data <= 32'd0;
      r_rsp_ne   <= 1'b0;
      r_rsp_lt   <= 1'b0;
      r_rsp_ovf  <= 1'b0;
      r_rsp_err  <= 1'b0;
    end else if (w_capture) begin
      r_rsp_data <= w_legal ? w_alu_y : 32'd0;
      r_rsp_ne   <= w_legal & w_alu_ne;
      r_rsp_lt   <= w_legal & w_alu_lt;
      r_rsp_ovf  <= w_legal & op_has_ovf(w_alu_op) & w_alu_ovf;
      r_rsp_err  <= ~w_legal;
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;
  assign rsp_ne    = r_rsp_ne;
  assign rsp_lt    = r_rsp_lt;
  assign rsp_ovf   = r_rsp_ovf;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed table-driven bench for alu_arbiter plus hand-written sequences for
// round-robin order, response back-pressure and reset mid-transaction.
module tb_alu_arbiter;
  import alu_pkg::*;

`ifdef ALU_ARB_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        r0_valid, r0_ready, r1_valid, r1_ready;
  logic [4:0]  r0_opcode, r0_shamt, r1_opcode, r1_shamt;
  logic [31:0] r0_a, r0_b, r1_a, r1_b;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [31:0] rsp_data;
  logic        rsp_ne, rsp_lt, rsp_ovf, rsp_err;

  int checks   = 0;
  int failures = 0;

  alu_arbiter #(.NREQ(2)) dut (
    .clock(clock), .reset(reset),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_opcode(r0_opcode),
    .r0_shamt(r0_shamt), .r0_a(r0_a), .r0_b(r0_b),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_opcode(r1_opcode),
    .r1_shamt(r1_shamt), .r1_a(r1_a), .r1_b(r1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_ne(rsp_ne), .rsp_lt(rsp_lt),
    .rsp_ovf(rsp_ovf), .rsp_err(rsp_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        port;
    logic [4:0]  op;
    logic [4:0]  sh;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] data;
    logic [4:0]  flags;  // {id, ne, lt, ovf, err}
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic port, input logic [4:0] op, input logic [4:0] sh,
                       input logic [31:0] a, input logic [31:0] b);
    if (port) begin
      r1_valid = 1'b1; r1_opcode = op; r1_shamt = sh; r1_a = a; r1_b = b;
    end else begin
      r0_valid = 1'b1; r0_opcode = op; r0_shamt = sh; r0_a = a; r0_b = b;
    end
  endtask

  task automatic clear_reqs();
    r0_valid = 1'b0;
    r1_valid = 1'b0;
  endtask

  // Call right after the accept edge; returns at the negedge where rsp_valid is seen.
  task automatic wait_rsp(input string name);
    int cyc;
    cyc = 0;
    do begin
      @(negedge clock);
      cyc++;
    end while (!rsp_valid && cyc < 8);
    check({name, "_latency"}, 64'(cyc), 64'(LAT));
  endtask

  function automatic logic [4:0] flags_now();
    return {rsp_id, rsp_ne, rsp_lt, rsp_ovf, rsp_err};
  endfunction

  initial begin
    vecs[0]  = '{1'b0, OP_ADD,   5'd0,  32'd7,        32'd5,        32'd12,       5'b01000};
    vecs[1]  = '{1'b0, OP_XOR,   5'd0,  32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 5'b01100};
    vecs[2]  = '{1'b1, 5'b00110, 5'd0,  32'd3,        32'd4,        32'd0,        5'b10001};
    vecs[3]  = '{1'b1, OP_SLL,   5'd31, 32'd1,        32'd0,        32'h80000000, 5'b11000};
    vecs[4]  = '{1'b0, OP_SUB,   5'd0,  32'd5,        32'd7,        32'hFFFFFFFE, 5'b01100};
    vecs[5]  = '{1'b1, OP_AND,   5'd0,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 5'b11100};
    vecs[6]  = '{1'b0, OP_OR,    5'd0,  32'h00000012, 32'h00000021, 32'h00000033, 5'b01100};
    vecs[7]  = '{1'b1, OP_SRA,   5'd4,  32'h80000000, 32'h80000000, 32'hF8000000, 5'b10000};
    vecs[8]  = '{1'b0, OP_ADD,   5'd0,  32'h7FFFFFFF, 32'd1,        32'h80000000, 5'b01010};
    vecs[9]  = '{1'b1, 5'b11111, 5'd0,  32'd5,        32'd5,        32'd0,        5'b10001};
    vecs[10] = '{1'b1, OP_SUB,   5'd0,  32'h80000000, 32'd1,        32'h7FFFFFFF, 5'b11110};

    r0_valid = 1'b0; r0_opcode = 5'd0; r0_shamt = 5'd0; r0_a = 32'd0; r0_b = 32'd0;
    r1_valid = 1'b0; r1_opcode = 5'd0; r1_shamt = 5'd0; r1_a = 32'd0; r1_b = 32'd0;
    rsp_ready = 1'b0;

    // Reset state.
    repeat (2) @(negedge clock);
    check("rst_valid", 64'(rsp_valid), 64'd0);
    check("rst_data", 64'(rsp_data), 64'd0);
    check("rst_flags", 64'(flags_now()), 64'd0);
    check("rst_ready", 64'({r1_ready, r0_ready}), 64'd0);

    // Both valid from reset: port 0 first, then port 1 (both stay valid).
    reset = 1'b0;
    rsp_ready = 1'b1;
    drive(1'b0, OP_SUB, 5'd0, 32'h7FFFFFFF, 32'hFFFFFFFF);
    drive(1'b1, OP_SUB, 5'd0, 32'h7FFFFFFF, 32'hFFFFFFFF);
    #1 check("rr_first_grant", 64'({r1_ready, r0_ready}), 64'h1);
    @(posedge clock);
    wait_rsp("rr_first");
    check("rr_first_data", 64'(rsp_data), 64'h80000000);
    check("rr_first_flags", 64'(flags_now()), 64'h0A);
    @(negedge clock);
    #1 check("rr_second_grant", 64'({r1_ready, r0_ready}), 64'h2);
    @(posedge clock);
    wait_rsp("rr_second");
    clear_reqs();
    check("rr_second_data", 64'(rsp_data), 64'h80000000);
    check("rr_second_flags", 64'(flags_now()), 64'h1A);

    // Table of single-port operations with rsp_ready held high.
    for (int i = 0; i < 11; i++) begin
      @(negedge clock);
      drive(vecs[i].port, vecs[i].op, vecs[i].sh, vecs[i].a, vecs[i].b);
      #1 check($sformatf("v%0d_ready", i), 64'({r1_ready, r0_ready}),
               vecs[i].port ? 64'h2 : 64'h1);
      @(posedge clock);
      wait_rsp($sformatf("v%0d", i));
      clear_reqs();
      check($sformatf("v%0d_data", i), 64'(rsp_data), 64'(vecs[i].data));
      check($sformatf("v%0d_flags", i), 64'(flags_now()), 64'(vecs[i].flags));
    end

    // Back-pressure: response held for 5 cycles; r1 valid meanwhile, then dropped.
    @(negedge clock);
    rsp_ready = 1'b0;
    drive(1'b0, OP_ADD, 5'd0, 32'd7, 32'd5);
    @(posedge clock);
    wait_rsp("hold");
    clear_reqs();
    drive(1'b1, OP_ADD, 5'd0, 32'd1, 32'd1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      check($sformatf("hold%0d_valid", c), 64'(rsp_valid), 64'd1);
      check($sformatf("hold%0d_data", c), 64'(rsp_data), 64'd12);
      check($sformatf("hold%0d_flags", c), 64'(flags_now()), 64'h08);
      check($sformatf("hold%0d_ready", c), 64'({r1_ready, r0_ready}), 64'd0);
    end
    clear_reqs();
    rsp_ready = 1'b1;
    @(negedge clock);
    check("hold_release_valid", 64'(rsp_valid), 64'd0);
    @(negedge clock);
    check("dropped_req_no_rsp", 64'(rsp_valid), 64'd0);

    // Reset while in RESP (last grant is port 0 at this point).
    rsp_ready = 1'b0;
    drive(1'b0, OP_ADD, 5'd0, 32'd7, 32'd5);
    @(posedge clock);
    wait_rsp("pre_reset");
    clear_reqs();
    reset = 1'b1;
    #1;
    check("mid_reset_valid", 64'(rsp_valid), 64'd0);
    check("mid_reset_data", 64'(rsp_data), 64'd0);
    check("mid_reset_flags", 64'(flags_now()), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    rsp_ready = 1'b1;
    drive(1'b0, OP_OR, 5'd0, 32'h00000012, 32'h00000021);
    drive(1'b1, OP_ADD, 5'd0, 32'd7, 32'd5);
    #1 check("post_reset_grant", 64'({r1_ready, r0_ready}), 64'h1);
    check("post_reset_no_rsp", 64'(rsp_valid), 64'd0);
    @(posedge clock);
    wait_rsp("post_reset");
    clear_reqs();
    check("post_reset_data", 64'(rsp_data), 64'h33);
    check("post_reset_flags", 64'(flags_now()), 64'h0C);

    @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
